i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target (slave) for the on-chip bus; the responder counterpart to the existing I2C master controller.
- Detects START/STOP, matches a 7-bit address, ACKs and delivers written bytes, and serves read bytes through a byte handshake.
- Stretches SCL while it waits for read data.
- Drives both lines open-drain: only low or Z, never high.

Parameters:
ADDR, 7'h50, own 7-bit target address
SYNC, 2, synchronizer flops on sda/scl inputs (2..3)

Ports:
clk  input  1  system clock, at least 10x SCL rate
reset  input  1  synchronous, active-low
sda  inout  1  I2C data, open-drain (0 or Z)
scl  inout  1  I2C clock; driven low only for stretching
datasend  input  8  next byte to return on a read
sendvalid  input  1  datasend valid; held until sended
sended  output  1  1-clk pulse: datasend latched into shifter
datareceive  output  8  last byte written by master
received  output  1  1-clk pulse: datareceive updated
rw  output  1  R/W bit of the current address byte (1 = read)
selected  output  1  high from address ACK until STOP/START/NACK
state  output  4  current FSM state code, debug

Behaviour:
Reset and line handling:
- Reset (reset==0 at posedge clk): state IDLE; sda and scl released (Z); sended=0, received=0, datareceive=0, rw=0, selected=0; bit counter=7.
- Reset mid-transfer releases both lines on the same edge.
- sda/scl pass through SYNC flops. Edges are detected against the previous synced value. Bus events are therefore seen SYNC+1 clk after the pin changes.
- START: synced sda falls while synced scl is high. Valid in any state, including repeated START. Action: go to ADDR, counter=7, selected=0, release sda.
- STOP: synced sda rises while synced scl is high. Action: go to IDLE, release both lines, selected=0. STOP has priority over every other transition on the same clk.
- Input bits are sampled on the scl rising edge. sda output changes only on the scl falling edge.

FSM states (codes 0..8):
- IDLE(0): wait for START.
- ADDR(1): shift 8 bits, MSB first.
  - Byte[7:1]==ADDR: latch rw=byte[0], go to ADDR_ACK.
  - Otherwise: go to IGNORE.
- ADDR_ACK(2):
  - On the next falling edge, drive sda low.
  - On the following falling edge, release sda and set selected=1.
  - Then go to RX (rw=0) or TX_LOAD (rw=1).
- RX(3): shift 8 bits.
  - On the 8th rising edge: datareceive<=byte, received pulses for 1 clk, go to RX_ACK.
- RX_ACK(4): drive sda low for the 9th clock (falling to falling edge), then return to RX with counter=7. Every write byte is ACKed.
- TX_LOAD(5):
  - Hold scl low (stretch) until sendvalid=1.
  - Then latch datasend, pulse sended for 1 clk, put bit7 on sda, release scl, go to TX.
  - If sendvalid is already high on entry, no stretch; latency 1 clk.
- TX(6): on each falling edge, present the next bit (Z for 1, 0 for 0).
  - After the 8th falling edge, release sda and go to TX_ACK.
- TX_ACK(7): sample sda on the 9th rising edge.
  - 0 (ACK): on the falling edge go to TX_LOAD.
  - 1 (NACK): selected=0, go to IGNORE.
- IGNORE(8): lines released; wait for START or STOP.

Boundary rules:
- General call (address 0) is NACKed unless ADDR==0.
- The 4-bit counter wraps 0 -> 7 at each byte end.
- received and sended are never high in the same clk.
- sendvalid asserted outside TX_LOAD is ignored, not queued.
- START or STOP arriving mid-byte aborts that byte: no received pulse, and an already-latched send byte is discarded.

Test Plan:
- Write: START, 0xA0 (addr 0x50, W), 0x3C, 0xF1, STOP -> ACK on all three 9th clocks; received pulses twice with datareceive 0x3C then 0xF1; rw=0; state returns to IDLE after STOP.
- Wrong address: START, 0xA2, 0x55, STOP -> sda never driven (NACK seen); no received pulse; state=IGNORE until STOP, then IDLE.
- Read with stretch: START, 0xA1; sendvalid held low for 200 clk after the address ACK -> scl held low for those 200 clk. Then datasend=0x96 with sendvalid -> sended pulse; master reads 0x96; master NACK -> IGNORE; STOP -> IDLE.
- Multi-byte read: sendvalid already high with 0x12, then 0x34; master ACKs, then NACKs -> bytes 0x12, 0x34 returned; no stretch; two sended pulses.
- Repeated START: write 0xA0, 0x07, then Sr, 0xA1, read 1 byte (0xE5), NACK, STOP -> received=0x07; rw switches to 1 after Sr; 0xE5 returned.
- Reset mid-byte: assert reset during bit 4 of a TX byte with sda driven low -> sda and scl Z on the next clk; all outputs at reset values; the next START/0xA0 transfer completes normally.

Source files
------------

// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave
// Purpose  : I2C target with 7-bit address match, byte-handshake read/write
//            ports and SCL stretching while read data is pending.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] ADDR = 7'h50,
    parameter int         SYNC = 2
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        sda,
    inout  wire        scl,
    input  logic [7:0] datasend,
    input  logic       sendvalid,
    output logic       sended,
    output logic [7:0] datareceive,
    output logic       received,
    output logic       rw,
    output logic       selected,
    output logic [3:0] state
);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_ADDR     = 4'd1;
    localparam logic [3:0] c_ADDR_ACK = 4'd2;
    localparam logic [3:0] c_RX       = 4'd3;
    localparam logic [3:0] c_RX_ACK   = 4'd4;
    localparam logic [3:0] c_TX_LOAD  = 4'd5;
    localparam logic [3:0] c_TX       = 4'd6;
    localparam logic [3:0] c_TX_ACK   = 4'd7;
    localparam logic [3:0] c_IGNORE   = 4'd8;

    logic [SYNC-1:0] r_sda_sync;
    logic [SYNC-1:0] r_scl_sync;
    logic            r_sda_prev;
    logic            r_scl_prev;
    logic [3:0]      r_state;
    logic [3:0]      r_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_datareceive;
    logic            r_sda_oe;
    logic            r_scl_oe;
    logic            r_rw;
    logic            r_selected;
    logic            r_sended;
    logic            r_received;
    logic            r_phase;

    logic            w_sda_s;
    logic            w_scl_s;
    logic            w_scl_rise;
    logic            w_scl_fall;
    logic            w_start;
    logic            w_stop;
    logic [7:0]      w_byte;

    assign w_sda_s    = r_sda_sync[SYNC-1];
    assign w_scl_s    = r_scl_sync[SYNC-1];
    assign w_scl_rise = w_scl_s & ~r_scl_prev;
    assign w_scl_fall = ~w_scl_s & r_scl_prev;
    // SCL must be high on both samples so a data change coincident with an SCL edge is not a bus event
    assign w_start    = w_scl_s & r_scl_prev & r_sda_prev & ~w_sda_s;
    assign w_stop     = w_scl_s & r_scl_prev & ~r_sda_prev & w_sda_s;
    assign w_byte     = {r_shift[6:0], w_sda_s};

    assign sda         = r_sda_oe ? 1'b0 : 1'bz;
    assign scl         = r_scl_oe ? 1'b0 : 1'bz;
    assign sended      = r_sended;
    assign received    = r_received;
    assign datareceive = r_datareceive;
    assign rw          = r_rw;
    assign selected    = r_selected;
    assign state       = r_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sda_sync <= '1;
            r_scl_sync <= '1;
            r_sda_prev <= 1'b1;
            r_scl_prev <= 1'b1;
        end else begin
            r_sda_sync <= {r_sda_sync[SYNC-2:0], sda};
            r_scl_sync <= {r_scl_sync[SYNC-2:0], scl};
            r_sda_prev <= w_sda_s;
            r_scl_prev <= w_scl_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_cnt         <= 4'd7;
            r_shift       <= 8'd0;
            r_datareceive <= 8'd0;
            r_sda_oe      <= 1'b0;
            r_scl_oe      <= 1'b0;
            r_rw          <= 1'b0;
            r_selected    <= 1'b0;
            r_sended      <= 1'b0;
            r_received    <= 1'b0;
            r_phase       <= 1'b0;
        end else begin
            r_sended   <= 1'b0;
            r_received <= 1'b0;
            if (w_stop) begin
                r_state    <= c_IDLE;
                r_sda_oe   <= 1'b0;
                r_scl_oe   <= 1'b0;
                r_selected <= 1'b0;
            end else if (w_start) begin
                r_state    <= c_ADDR;
                r_cnt      <= 4'd7;
                r_selected <= 1'b0;
                r_sda_oe   <= 1'b0;
                r_scl_oe   <= 1'b0;
            end else begin
                case (r_state)
                    c_ADDR, c_RX: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_cnt == 4'd0) begin
                                r_cnt   <= 4'd7;
                                r_phase <= 1'b0;
                                if (r_state == c_RX) begin
                                    r_datareceive <= w_byte;
                                    r_received    <= 1'b1;
                                    r_state       <= c_RX_ACK;
                                end else if (w_byte[7:1] == ADDR) begin
                                    r_rw    <= w_byte[0];
                                    r_state <= c_ADDR_ACK;
                                end else begin
                                    r_state <= c_IGNORE;
                                end
                            end else begin
                                r_cnt <= r_cnt - 4'd1;
                            end
                        end
                    end
                    c_ADDR_ACK, c_RX_ACK: begin
                        // first falling edge asserts ACK, second ends the 9th clock
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_oe <= 1'b1;
                                r_phase  <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_cnt    <= 4'd7;
                                if (r_state == c_RX_ACK) begin
                                    r_state <= c_RX;
                                end else begin
                                    r_selected <= 1'b1;
                                    r_state    <= r_rw ? c_TX_LOAD : c_RX;
                                end
                            end
                        end
                    end
                    c_TX_LOAD: begin
                        if (sendvalid) begin
                            r_shift  <= datasend;
                            r_sended <= 1'b1;
                            r_sda_oe <= ~datasend[7];
                            r_scl_oe <= 1'b0;
                            r_cnt    <= 4'd7;
                            r_state  <= c_TX;
                        end else begin
                            r_scl_oe <= 1'b1;
                        end
                    end
                    c_TX: begin
                        if (w_scl_fall) begin
                            if (r_cnt == 4'd0) begin
                                r_sda_oe <= 1'b0;
                                r_cnt    <= 4'd7;
                                r_phase  <= 1'b0;
                                r_state  <= c_TX_ACK;
                            end else begin
                                r_cnt    <= r_cnt - 4'd1;
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    c_TX_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda_s) begin
                                r_selected <= 1'b0;
                                r_state    <= c_IGNORE;
                            end else begin
                                r_phase <= 1'b1;
                            end
                        end else if (w_scl_fall && r_phase) begin
                            r_state <= c_TX_LOAD;
                        end
                    end
                    c_IDLE, c_IGNORE: begin
                        r_sda_oe <= 1'b0;
                        r_scl_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= c_IDLE;
                        r_sda_oe <= 1'b0;
                        r_scl_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave
// Purpose  : Directed bench for i2c_slave with a bit-level open-drain master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

    localparam int H = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m_sda_low = 1'b0;
    logic       m_scl_low = 1'b0;
    logic [7:0] datasend = 8'd0;
    logic       sendvalid = 1'b0;
    logic       sended;
    logic       received;
    logic       rw;
    logic       selected;
    logic [7:0] datareceive;
    logic [3:0] state;
    wire        sda;
    wire        scl;

    int tests = 0;
    int fails = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int overlap = 0;
    int dut_sda_cnt = 0;
    int max_stretch = 0;
    logic [7:0] rx_log [$];

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    assign scl = m_scl_low ? 1'b0 : 1'bz;
    pullup (sda);
    pullup (scl);

    always #5 clk = ~clk;

    i2c_slave #(.ADDR(7'h50), .SYNC(2)) dut (
        .clk(clk), .reset(reset), .sda(sda), .scl(scl),
        .datasend(datasend), .sendvalid(sendvalid), .sended(sended),
        .datareceive(datareceive), .received(received), .rw(rw),
        .selected(selected), .state(state)
    );

    always @(negedge clk) begin
        if (received) begin
            rx_cnt = rx_cnt + 1;
            rx_log.push_back(datareceive);
        end
        if (sended) tx_cnt = tx_cnt + 1;
        if (received && sended) overlap = overlap + 1;
        if (sda === 1'b0 && !m_sda_low) dut_sda_cnt = dut_sda_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_release();
        int n;
        n = 0;
        m_scl_low = 1'b0;
        #1;
        while (scl !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (scl !== 1'b1) begin
            tests++; fails++;
            $display("FAIL scl_release: scl=%b after %0d clk, expected 1", scl, n);
        end
        if (n > max_stretch) max_stretch = n;
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        wait_clk(2);
        m_sda_low = ~b;
        wait_clk(H - 2);
        scl_release();
        wait_clk(H / 2);
        s = sda;
        wait_clk(H / 2);
        m_scl_low = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(nack, s);
    endtask

    task automatic m_start();
        wait_clk(H);
        m_sda_low = 1'b1;
        wait_clk(H);
        m_scl_low = 1'b1;
    endtask

    task automatic m_rstart();
        wait_clk(2);
        m_sda_low = 1'b0;
        wait_clk(H - 2);
        scl_release();
        wait_clk(H);
        m_sda_low = 1'b1;
        wait_clk(H);
        m_scl_low = 1'b1;
    endtask

    task automatic m_stop();
        wait_clk(2);
        m_sda_low = 1'b1;
        wait_clk(H - 2);
        scl_release();
        wait_clk(H);
        m_sda_low = 1'b0;
        wait_clk(H);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wait_clk(3);
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d, expected 0", state); end
        tests++; if (sended !== 1'b0) begin fails++; $display("FAIL reset_sended: got %b, expected 0", sended); end
        tests++; if (received !== 1'b0) begin fails++; $display("FAIL reset_received: got %b, expected 0", received); end
        tests++; if (datareceive !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, expected 00", datareceive); end
        tests++; if (rw !== 1'b0 || selected !== 1'b0) begin fails++; $display("FAIL reset_rw_sel: got %b%b, expected 00", rw, selected); end
        tests++; if (sda !== 1'b1 || scl !== 1'b1) begin fails++; $display("FAIL reset_lines: got sda=%b scl=%b, expected 1 1", sda, scl); end
        reset = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_write();
        int rx0;
        logic a0, a1, a2;
        rx0 = rx_cnt;
        m_start();
        write_byte(8'hA0, a0);
        write_byte(8'h3C, a1);
        tests++; if (selected !== 1'b1 || rw !== 1'b0) begin fails++; $display("FAIL write_sel_rw: got sel=%b rw=%b, expected 1 0", selected, rw); end
        write_byte(8'hF1, a2);
        tests++; if ({a0, a1, a2} !== 3'b000) begin fails++; $display("FAIL write_acks: got %b, expected 000", {a0, a1, a2}); end
        tests++; if (rx_cnt - rx0 != 2) begin fails++; $display("FAIL write_rx_count: got %0d, expected 2", rx_cnt - rx0); end
        else begin
            tests++; if (rx_log[rx0] !== 8'h3C || rx_log[rx0 + 1] !== 8'hF1) begin fails++; $display("FAIL write_data: got %h %h, expected 3c f1", rx_log[rx0], rx_log[rx0 + 1]); end
        end
        m_stop();
        tests++; if (state !== 4'd0 || selected !== 1'b0) begin fails++; $display("FAIL write_stop: got state=%0d sel=%b, expected 0 0", state, selected); end
    endtask

    task automatic test_wrong_addr();
        int rx0, d0;
        logic a0, a1;
        rx0 = rx_cnt;
        d0 = dut_sda_cnt;
        m_start();
        write_byte(8'hA2, a0);
        tests++; if (state !== 4'd8) begin fails++; $display("FAIL wrong_ignore: got state %0d, expected 8", state); end
        write_byte(8'h55, a1);
        tests++; if ({a0, a1} !== 2'b11) begin fails++; $display("FAIL wrong_nack: got %b, expected 11", {a0, a1}); end
        tests++; if (dut_sda_cnt != d0 || rx_cnt != rx0) begin fails++; $display("FAIL wrong_quiet: got drive=%0d rx=%0d, expected 0 0", dut_sda_cnt - d0, rx_cnt - rx0); end
        m_stop();
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL wrong_stop: got state %0d, expected 0", state); end
    endtask

    task automatic test_read_stretch();
        int tx0;
        logic a0;
        logic [7:0] d;
        tx0 = tx_cnt;
        m_start();
        write_byte(8'hA1, a0);
        tests++; if (a0 !== 1'b0 || rw !== 1'b1) begin fails++; $display("FAIL stretch_addr: got ack=%b rw=%b, expected 0 1", a0, rw); end
        max_stretch = 0;
        fork
            read_byte(1'b1, d);
            begin
                int n, low;
                n = 0;
                low = 0;
                while (state !== 4'd5 && n < 200) begin wait_clk(1); n++; end
                tests++; if (state !== 4'd5) begin fails++; $display("FAIL stretch_load: got state %0d, expected 5", state); end
                repeat (200) begin
                    wait_clk(1);
                    if (scl === 1'b0) low++;
                end
                tests++; if (low != 200) begin fails++; $display("FAIL stretch_low: got %0d low clk, expected 200", low); end
                datasend = 8'h96;
                sendvalid = 1'b1;
                n = 0;
                while (sended !== 1'b1 && n < 50) begin wait_clk(1); n++; end
                tests++; if (sended !== 1'b1) begin fails++; $display("FAIL stretch_sended: got %b, expected 1", sended); end
                sendvalid = 1'b0;
            end
        join
        tests++; if (d !== 8'h96) begin fails++; $display("FAIL stretch_data: got %h, expected 96", d); end
        tests++; if (max_stretch < 150 || max_stretch > 250) begin fails++; $display("FAIL stretch_len: got %0d, expected 150..250", max_stretch); end
        tests++; if (state !== 4'd8 || tx_cnt - tx0 != 1) begin fails++; $display("FAIL stretch_nack: got state=%0d sended=%0d, expected 8 1", state, tx_cnt - tx0); end
        m_stop();
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL stretch_stop: got state %0d, expected 0", state); end
    endtask

    task automatic test_multi_read();
        int tx0, ov0;
        logic a0;
        logic [7:0] d0, d1;
        tx0 = tx_cnt;
        ov0 = overlap;
        datasend = 8'h12;
        sendvalid = 1'b1;
        m_start();
        write_byte(8'hA1, a0);
        max_stretch = 0;
        fork
            begin
                read_byte(1'b0, d0);
                read_byte(1'b1, d1);
            end
            begin
                int n;
                n = 0;
                while (sended !== 1'b1 && n < 3000) begin wait_clk(1); n++; end
                tests++; if (sended !== 1'b1) begin fails++; $display("FAIL multi_first_sended: got %b, expected 1", sended); end
                datasend = 8'h34;
                wait_clk(1);
                n = 0;
                while (sended !== 1'b1 && n < 3000) begin wait_clk(1); n++; end
                tests++; if (sended !== 1'b1) begin fails++; $display("FAIL multi_second_sended: got %b, expected 1", sended); end
                sendvalid = 1'b0;
            end
        join
        tests++; if (a0 !== 1'b0 || d0 !== 8'h12 || d1 !== 8'h34) begin fails++; $display("FAIL multi_data: got ack=%b %h %h, expected 0 12 34", a0, d0, d1); end
        tests++; if (max_stretch != 0) begin fails++; $display("FAIL multi_stretch: got %0d, expected 0", max_stretch); end
        tests++; if (tx_cnt - tx0 != 2 || overlap != ov0) begin fails++; $display("FAIL multi_pulses: got sended=%0d overlap=%0d, expected 2 0", tx_cnt - tx0, overlap - ov0); end
        m_stop();
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL multi_stop: got state %0d, expected 0", state); end
    endtask

    task automatic test_back_to_back();
        int rx0;
        logic a0, a1, a2;
        logic [7:0] d;
        rx0 = rx_cnt;
        m_start();
        write_byte(8'hA0, a0);
        write_byte(8'h07, a1);
        tests++; if (rw !== 1'b0) begin fails++; $display("FAIL rs_rw_before: got %b, expected 0", rw); end
        datasend = 8'hE5;
        sendvalid = 1'b1;
        m_rstart();
        write_byte(8'hA1, a2);
        tests++; if (rw !== 1'b1 || {a0, a1, a2} !== 3'b000) begin fails++; $display("FAIL rs_addr: got rw=%b acks=%b, expected 1 000", rw, {a0, a1, a2}); end
        fork
            read_byte(1'b1, d);
            begin
                int n;
                n = 0;
                while (sended !== 1'b1 && n < 3000) begin wait_clk(1); n++; end
                tests++; if (sended !== 1'b1) begin fails++; $display("FAIL rs_sended: got %b, expected 1", sended); end
                sendvalid = 1'b0;
            end
        join
        tests++; if (d !== 8'hE5) begin fails++; $display("FAIL rs_data: got %h, expected e5", d); end
        tests++; if (rx_cnt - rx0 != 1) begin fails++; $display("FAIL rs_rx_count: got %0d, expected 1", rx_cnt - rx0); end
        else begin
            tests++; if (rx_log[rx0] !== 8'h07) begin fails++; $display("FAIL rs_rx_data: got %h, expected 07", rx_log[rx0]); end
        end
        m_stop();
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL rs_stop: got state %0d, expected 0", state); end
    endtask

    task automatic test_reset_mid();
        int rx0;
        logic a0, a1, s;
        datasend = 8'h00;
        sendvalid = 1'b1;
        m_start();
        write_byte(8'hA1, a0);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, s);
        wait_clk(6);
        tests++; if (sda !== 1'b0 || state !== 4'd6) begin fails++; $display("FAIL mid_drive: got sda=%b state=%0d, expected 0 6", sda, state); end
        sendvalid = 1'b0;
        m_scl_low = 1'b0;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(1);
        tests++; if (sda !== 1'b1 || scl !== 1'b1) begin fails++; $display("FAIL mid_lines: got sda=%b scl=%b, expected 1 1", sda, scl); end
        tests++; if (state !== 4'd0 || selected !== 1'b0 || rw !== 1'b0 || datareceive !== 8'h00) begin
            fails++; $display("FAIL mid_outputs: got state=%0d sel=%b rw=%b data=%h, expected 0 0 0 00", state, selected, rw, datareceive);
        end
        reset = 1'b1;
        wait_clk(H);
        rx0 = rx_cnt;
        m_start();
        write_byte(8'hA0, a0);
        write_byte(8'h5A, a1);
        m_stop();
        tests++; if ({a0, a1} !== 2'b00 || rx_cnt - rx0 != 1) begin fails++; $display("FAIL mid_resume: got acks=%b rx=%0d, expected 00 1", {a0, a1}, rx_cnt - rx0); end
        else begin
            tests++; if (rx_log[rx0] !== 8'h5A || state !== 4'd0) begin fails++; $display("FAIL mid_resume_data: got %h state=%0d, expected 5a 0", rx_log[rx0], state); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_read_stretch();
        test_multi_read();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
